player_cache: RTL and testbench
===============================

Name: player_cache

Overview:
- Small direct-mapped write-back cache between the pokemon controller and the bridge.
- Pokemon issues 64-bit player-record reads and writes by 8-bit player ID. Hits are served locally in one cycle.
- Misses and dirty evictions become single-beat bridge transactions (C_in_valid / C_out_valid). This cuts DRAM round-trips for back-to-back operations on the same player.
- A flush command writes back every dirty line before the pattern checks DRAM contents.

Parameters:
- NUM_LINES, 4, number of cache lines; power of 2; index = id[log2(NUM_LINES)-1:0].
- ADDR_W, 8, player ID / C_addr width.
- DATA_W, 64, player record / C_data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  one-cycle request pulse; sampled only while busy=0.
- req_rw  in  1  1=read, 0=write.
- req_id  in  ADDR_W  player ID.
- req_data  in  DATA_W  write data; full record, no byte enables.
- flush_req  in  1  one-cycle flush pulse.
- busy  out  1  high from the cycle after acceptance until completion.
- resp_valid  out  1  one-cycle completion pulse for a request.
- resp_data  out  DATA_W  read data while resp_valid=1, else 0.
- flush_done  out  1  one-cycle pulse when the flush completes.
- C_in_valid  out  1  one-cycle bridge command pulse.
- C_r_wb  out  1  1=read, 0=write; valid with C_in_valid.
- C_addr  out  ADDR_W  bridge address; valid with C_in_valid.
- C_data_w  out  DATA_W  bridge write data; valid with C_in_valid.
- C_out_valid  in  1  one-cycle bridge completion pulse, for both reads and writes.
- C_data_r  in  DATA_W  bridge read data; valid with C_out_valid.

Behaviour:
- Reset (async, rst_n=0): all outputs 0. All valid and dirty bits 0. FSM in IDLE. Pending flush cleared. Line data need not reset.
- Reset mid-operation: abort immediately; dirty data is lost. Any C_out_valid arriving after reset is ignored.
- Line state: data[DATA_W], tag = id[ADDR_W-1:idx_bits], valid, dirty.
- FSM states: IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP, FL_SCAN, FL_WAIT.
- IDLE, req_valid=1, hit: next cycle is RESP.
  - Read hit: resp_data = line data.
  - Write hit: line data = req_data, dirty=1.
  - Total latency: resp_valid 1 cycle after req_valid. busy stays 0 on a hit.
- IDLE, req_valid=1, miss: busy=1 next cycle.
  - Victim valid and dirty: go to WB_REQ.
  - Otherwise, read miss: go to FILL_REQ.
  - Otherwise, write miss: install the line (valid=1, dirty=1, data=req_data), then go to RESP. No DRAM read.
- WB_REQ (1 cycle): C_in_valid=1, C_r_wb=0, C_addr={victim tag, idx}, C_data_w=victim data. Then WB_WAIT.
- WB_WAIT: on C_out_valid, clear victim dirty.
  - Read request: go to FILL_REQ.
  - Write request: install as for a write miss, then RESP.
- FILL_REQ (1 cycle): C_in_valid=1, C_r_wb=1, C_addr=req_id, C_data_w=0. Then FILL_WAIT.
- FILL_WAIT: on C_out_valid, line data = C_data_r, valid=1, dirty=0, tag updated. Then RESP with resp_data = C_data_r.
- RESP (1 cycle): resp_valid=1, busy falls.
  - If a flush is pending, go to FL_SCAN.
  - Otherwise go to IDLE.
- Request latching: req_id, req_rw and req_data are captured at acceptance. Inputs changing during busy are ignored.
- req_valid while busy=1 is dropped. Bench must not do this.
- flush_req in IDLE, no req_valid: busy=1, go to FL_SCAN starting at index 0.
- flush_req with req_valid in the same cycle: the request is served first; the flush is held pending.
- flush_req while busy: held pending. Multiple pulses collapse into one.
- FL_SCAN: one cycle per index.
  - Dirty line: issue a write (same signals as WB_REQ), go to FL_WAIT. On C_out_valid, clear dirty and return to FL_SCAN at the next index.
  - Clean line: advance to the next index.
  - After the last index: flush_done=1 for 1 cycle, busy=0, go to IDLE.
  - Lines stay valid after a flush.
- Flush with no dirty lines: flush_done NUM_LINES+1 cycles after flush_req.
- C_out_valid outside WB_WAIT, FILL_WAIT and FL_WAIT is ignored.
- C_in_valid is never asserted while a bridge transaction is outstanding (at most 1 outstanding).
- C_addr, C_r_wb and C_data_w return to 0 when C_in_valid=0.

Test Plan:
- Cold read id=0x15: one C_in_valid with C_r_wb=1, C_addr=0x15. Bridge returns 0x0123_4567_89AB_CDEF → resp_valid once with that data. Re-read id=0x15 → resp_valid the next cycle, no C_in_valid.
- Write hit: write id=0x15 data=0xFFFF_0000_FFFF_0000 → resp_valid after 1 cycle, no bridge traffic. Subsequent read returns the new value.
- Dirty eviction: read id=0x19 (same index 1) → write to C_addr=0x15 with data 0xFFFF_0000_FFFF_0000, then read C_addr=0x19, strictly in that order, one outstanding.
- Write miss on clean/invalid line id=0x22 → no bridge traffic, resp_valid 1 cycle later. Flush → exactly one write C_addr=0x22, then flush_done.
- Simultaneous req_valid (read hit id=0x19) and flush_req → resp_valid first, then flush writes only the dirty lines in index order 0..3, then one flush_done pulse. Flush with all lines clean → flush_done 5 cycles after flush_req.
- Assert rst_n=0 during FILL_WAIT → all outputs 0 and all lines invalid. A late C_out_valid is ignored. Next read of the same id issues a fresh C_in_valid.

Source files
------------

// File: rtl/player_cache.sv
// player_cache: direct-mapped write-back cache of 64-bit player records
// sitting between the pokemon controller and the DRAM bridge. Hits are
// answered locally one cycle after the request. Misses and dirty evictions
// turn into single-beat bridge transactions. A flush writes back every dirty
// line in index order.
module player_cache #(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_id,
  input  logic [DATA_W-1:0] req_data,
  input  logic              flush_req,
  output logic              busy,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              flush_done,
  output logic              C_in_valid,
  output logic              C_r_wb,
  output logic [ADDR_W-1:0] C_addr,
  output logic [DATA_W-1:0] C_data_w,
  input  logic              C_out_valid,
  input  logic [DATA_W-1:0] C_data_r
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP, FL_SCAN, FL_WAIT
  } stateT;

  stateT state;

  logic [DATA_W-1:0] lineData [NUM_LINES];
  logic [TAG_W-1:0]  lineTag  [NUM_LINES];
  logic [NUM_LINES-1:0] lineValid;
  logic [NUM_LINES-1:0] lineDirty;

  logic              reqRw;
  logic [ADDR_W-1:0] reqId;
  logic [DATA_W-1:0] reqData;
  logic              flushPending;
  logic [IDX_W-1:0]  scanIdx;

  logic [IDX_W-1:0] inIdx;
  logic [TAG_W-1:0] inTag;
  logic             inHit;
  logic [IDX_W-1:0] reqIdx;
  logic [TAG_W-1:0] reqTag;

  assign inIdx  = req_id[IDX_W-1:0];
  assign inTag  = req_id[ADDR_W-1:IDX_W];
  assign inHit  = lineValid[inIdx] && (lineTag[inIdx] == inTag);
  assign reqIdx = reqId[IDX_W-1:0];
  assign reqTag = reqId[ADDR_W-1:IDX_W];

  // Controller: line state, request latching, bridge sequencing and flush scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      flush_done   <= 1'b0;
      C_in_valid   <= 1'b0;
      C_r_wb       <= 1'b0;
      C_addr       <= '0;
      C_data_w     <= '0;
      lineValid    <= '0;
      lineDirty    <= '0;
      reqRw        <= 1'b0;
      reqId        <= '0;
      reqData      <= '0;
      flushPending <= 1'b0;
      scanIdx      <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        lineTag[i]  <= '0;
        lineData[i] <= '0;
      end
    end else begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      flush_done <= 1'b0;
      C_in_valid <= 1'b0;
      C_r_wb     <= 1'b0;
      C_addr     <= '0;
      C_data_w   <= '0;

      if (flush_req && !(state == IDLE && !req_valid)) begin
        flushPending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            reqRw   <= req_rw;
            reqId   <= req_id;
            reqData <= req_data;
            if (inHit) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              if (req_rw) begin
                resp_data <= lineData[inIdx];
              end else begin
                lineData[inIdx]  <= req_data;
                lineDirty[inIdx] <= 1'b1;
              end
            end else begin
              busy <= 1'b1;
              if (lineValid[inIdx] && lineDirty[inIdx]) begin
                state      <= WB_REQ;
                C_in_valid <= 1'b1;
                C_addr     <= {lineTag[inIdx], inIdx};
                C_data_w   <= lineData[inIdx];
              end else if (req_rw) begin
                state      <= FILL_REQ;
                C_in_valid <= 1'b1;
                C_r_wb     <= 1'b1;
                C_addr     <= req_id;
              end else begin
                lineData[inIdx]  <= req_data;
                lineTag[inIdx]   <= inTag;
                lineValid[inIdx] <= 1'b1;
                lineDirty[inIdx] <= 1'b1;
                state            <= RESP;
                resp_valid       <= 1'b1;
              end
            end
          end else if (flush_req || flushPending) begin
            busy         <= 1'b1;
            state        <= FL_SCAN;
            scanIdx      <= '0;
            flushPending <= 1'b0;
          end
        end

        WB_REQ: state <= WB_WAIT;

        WB_WAIT: begin
          if (C_out_valid) begin
            lineDirty[reqIdx] <= 1'b0;
            if (reqRw) begin
              state      <= FILL_REQ;
              C_in_valid <= 1'b1;
              C_r_wb     <= 1'b1;
              C_addr     <= reqId;
            end else begin
              lineData[reqIdx]  <= reqData;
              lineTag[reqIdx]   <= reqTag;
              lineValid[reqIdx] <= 1'b1;
              lineDirty[reqIdx] <= 1'b1;
              state             <= RESP;
              resp_valid        <= 1'b1;
            end
          end
        end

        FILL_REQ: state <= FILL_WAIT;

        FILL_WAIT: begin
          if (C_out_valid) begin
            lineData[reqIdx]  <= C_data_r;
            lineTag[reqIdx]   <= reqTag;
            lineValid[reqIdx] <= 1'b1;
            lineDirty[reqIdx] <= 1'b0;
            resp_valid        <= 1'b1;
            resp_data         <= C_data_r;
            state             <= RESP;
          end
        end

        RESP: begin
          if (flushPending || flush_req) begin
            state        <= FL_SCAN;
            scanIdx      <= '0;
            busy         <= 1'b1;
            flushPending <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        FL_SCAN: begin
          if (lineValid[scanIdx] && lineDirty[scanIdx]) begin
            state      <= FL_WAIT;
            C_in_valid <= 1'b1;
            C_addr     <= {lineTag[scanIdx], scanIdx};
            C_data_w   <= lineData[scanIdx];
          end else if (scanIdx == LAST_IDX) begin
            flush_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            scanIdx <= scanIdx + 1'b1;
          end
        end

        FL_WAIT: begin
          if (C_out_valid) begin
            lineDirty[scanIdx] <= 1'b0;
            if (scanIdx == LAST_IDX) begin
              flush_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              scanIdx <= scanIdx + 1'b1;
              state   <= FL_SCAN;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_cache.sv
// tb_player_cache: scoreboard bench for player_cache. Expected responses and
// expected bridge commands are queued as stimulus is applied and popped as
// the DUT produces them; a small bridge model answers each command after a
// fixed delay from its own memory.
module tb_player_cache;

  localparam int NUM_LINES = 4;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 64;

  typedef struct {
    logic              chk;
    logic [DATA_W-1:0] data;
  } respT;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmdT;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_rw = 1'b0;
  logic [ADDR_W-1:0] req_id = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              flush_req = 1'b0;
  logic              busy;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              flush_done;
  logic              C_in_valid;
  logic              C_r_wb;
  logic [ADDR_W-1:0] C_addr;
  logic [DATA_W-1:0] C_data_w;
  logic              C_out_valid = 1'b0;
  logic [DATA_W-1:0] C_data_r = '0;

  int checks = 0;
  int errors = 0;
  int respCount = 0;
  int respTarget = 0;
  int flushDoneCount = 0;
  int flushTarget = 0;
  int cmdCount = 0;

  respT respQ[$];
  cmdT  expCmdQ[$];

  logic [DATA_W-1:0] mem [256];
  int                bridgeTimer = 0;
  logic              outstanding = 1'b0;
  logic              pendRw = 1'b0;
  logic [ADDR_W-1:0] pendAddr = '0;
  logic [DATA_W-1:0] pendData = '0;

  player_cache #(
    .NUM_LINES(NUM_LINES),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_rw(req_rw),
    .req_id(req_id),
    .req_data(req_data),
    .flush_req(flush_req),
    .busy(busy),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .flush_done(flush_done),
    .C_in_valid(C_in_valid),
    .C_r_wb(C_r_wb),
    .C_addr(C_addr),
    .C_data_w(C_data_w),
    .C_out_valid(C_out_valid),
    .C_data_r(C_data_r)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] initVal(input logic [ADDR_W-1:0] a);
    return {56'hD0D0_5EED_0000_00, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pushCmd(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    cmdT c;
    c.rw = rw;
    c.addr = addr;
    c.data = data;
    expCmdQ.push_back(c);
  endtask

  // kind: 0 = hit, 1 = miss that goes to the bridge, 2 = write miss installed locally
  task automatic applyStimulus(input logic rw, input logic [ADDR_W-1:0] id, input logic [DATA_W-1:0] data,
                               input logic flush, input int kind, input logic chk, input logic [DATA_W-1:0] expData);
    respT e;
    e.chk = chk;
    e.data = expData;
    respQ.push_back(e);
    respTarget++;
    if (flush) flushTarget++;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_rw = rw;
    req_id = id;
    req_data = data;
    flush_req = flush;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_id = '0;
    req_data = '0;
    flush_req = 1'b0;
    checkOutput($sformatf("busyAccept_%02h", id), 64'(busy), 64'(kind != 0));
    checkOutput($sformatf("respAccept_%02h", id), 64'(resp_valid), 64'(kind != 1));
  endtask

  task automatic issueFlush();
    flushTarget++;
    @(posedge clk); #1;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    checkOutput("flushBusy", 64'(busy), 64'(1));
  endtask

  task automatic waitResp();
    for (int i = 0; i < 200; i++) begin
      if (respCount >= respTarget) break;
      @(posedge clk);
    end
    if (respCount < respTarget) checkOutput("respTimeout", 64'(respCount), 64'(respTarget));
    @(posedge clk); #1;
  endtask

  task automatic waitFlush();
    for (int i = 0; i < 200; i++) begin
      if (flushDoneCount >= flushTarget) break;
      @(posedge clk);
    end
    if (flushDoneCount < flushTarget) checkOutput("flushTimeout", 64'(flushDoneCount), 64'(flushTarget));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flushDoneCount", 64'(flushDoneCount), 64'(flushTarget));
  endtask

  task automatic checkQueuesEmpty(input string tag);
    checkOutput({tag, "_cmdQ"}, 64'(expCmdQ.size()), 64'(0));
    checkOutput({tag, "_respQ"}, 64'(respQ.size()), 64'(0));
  endtask

  task automatic checkOutputsZero(input string tag);
    checkOutput({tag, "_ctl"}, 64'({busy, resp_valid, flush_done, C_in_valid, C_r_wb}), 64'(0));
    checkOutput({tag, "_respData"}, resp_data, 64'(0));
    checkOutput({tag, "_cAddr"}, 64'(C_addr), 64'(0));
    checkOutput({tag, "_cDataW"}, C_data_w, 64'(0));
  endtask

  // Bridge model and output monitor, evaluated on the falling edge.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = initVal(8'(i));
    mem[8'h15] = 64'h0123_4567_89AB_CDEF;
    mem[8'h19] = 64'h1919_1919_1919_1919;
    forever begin
      @(negedge clk);
      C_out_valid = 1'b0;
      C_data_r = '0;
      if (bridgeTimer > 0) begin
        bridgeTimer--;
        if (bridgeTimer == 0) begin
          C_out_valid = 1'b1;
          if (pendRw) C_data_r = mem[pendAddr];
          else mem[pendAddr] = pendData;
          outstanding = 1'b0;
        end
      end
      if (resp_valid) begin
        respCount++;
        if (respQ.size() == 0) begin
          checkOutput("respUnexpected", 64'(1), 64'(0));
        end else begin
          respT e;
          e = respQ.pop_front();
          if (e.chk) checkOutput("respData", resp_data, e.data);
        end
      end else if (resp_data != '0) begin
        checkOutput("respDataIdle", resp_data, 64'(0));
      end
      if (flush_done) begin
        flushDoneCount++;
        if (flushDoneCount > flushTarget) checkOutput("flushDoneExtra", 64'(flushDoneCount), 64'(flushTarget));
      end
      if (C_in_valid) begin
        cmdCount++;
        if (outstanding) checkOutput("cmdOverlap", 64'(1), 64'(0));
        if (expCmdQ.size() == 0) begin
          checkOutput("cmdUnexpected", 64'(1), 64'(0));
        end else begin
          cmdT c;
          c = expCmdQ.pop_front();
          checkOutput("cmdRw", 64'(C_r_wb), 64'(c.rw));
          checkOutput("cmdAddr", 64'(C_addr), 64'(c.addr));
          checkOutput("cmdData", C_data_w, c.data);
        end
        outstanding = 1'b1;
        pendRw = C_r_wb;
        pendAddr = C_addr;
        pendData = C_data_w;
        bridgeTimer = 3;
      end else if (C_r_wb || C_addr != '0 || C_data_w != '0) begin
        checkOutput("cmdIdleZero", 64'({C_r_wb, C_addr}) | C_data_w, 64'(0));
      end
    end
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  // Main stimulus sequence.
  initial begin
    int cmdBefore;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutputsZero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] cold read then hit on 0x15");
    pushCmd(1'b1, 8'h15, '0);
    applyStimulus(1'b1, 8'h15, '0, 1'b0, 1, 1'b1, 64'h0123_4567_89AB_CDEF);
    waitResp();
    applyStimulus(1'b1, 8'h15, '0, 1'b0, 0, 1'b1, 64'h0123_4567_89AB_CDEF);
    waitResp();

    $display("[TB] write hit on 0x15 and read back");
    applyStimulus(1'b0, 8'h15, 64'hFFFF_0000_FFFF_0000, 1'b0, 0, 1'b0, '0);
    waitResp();
    applyStimulus(1'b1, 8'h15, '0, 1'b0, 0, 1'b1, 64'hFFFF_0000_FFFF_0000);
    waitResp();
    checkQueuesEmpty("hits");

    $display("[TB] dirty eviction by 0x19");
    pushCmd(1'b0, 8'h15, 64'hFFFF_0000_FFFF_0000);
    pushCmd(1'b1, 8'h19, '0);
    applyStimulus(1'b1, 8'h19, '0, 1'b0, 1, 1'b1, 64'h1919_1919_1919_1919);
    waitResp();
    checkQueuesEmpty("evict");

    $display("[TB] write miss on 0x22 then flush");
    applyStimulus(1'b0, 8'h22, 64'h2222_0000_0000_0022, 1'b0, 2, 1'b0, '0);
    waitResp();
    pushCmd(1'b0, 8'h22, 64'h2222_0000_0000_0022);
    issueFlush();
    waitFlush();
    checkQueuesEmpty("flush1");

    $display("[TB] request and flush together, flush in index order");
    applyStimulus(1'b0, 8'h19, 64'hAAAA_0000_0000_0019, 1'b0, 0, 1'b0, '0);
    waitResp();
    applyStimulus(1'b0, 8'h13, 64'hBBBB_0000_0000_0013, 1'b0, 2, 1'b0, '0);
    waitResp();
    applyStimulus(1'b0, 8'h20, 64'hCCCC_0000_0000_0020, 1'b0, 2, 1'b0, '0);
    waitResp();
    pushCmd(1'b0, 8'h20, 64'hCCCC_0000_0000_0020);
    pushCmd(1'b0, 8'h19, 64'hAAAA_0000_0000_0019);
    pushCmd(1'b0, 8'h13, 64'hBBBB_0000_0000_0013);
    applyStimulus(1'b1, 8'h19, '0, 1'b1, 0, 1'b1, 64'hAAAA_0000_0000_0019);
    waitResp();
    waitFlush();
    checkQueuesEmpty("flush2");

    $display("[TB] flush with all lines clean");
    issueFlush();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flushCleanEarly", 64'(flush_done), 64'(0));
    @(posedge clk); #1;
    checkOutput("flushCleanLatency", 64'(flush_done), 64'(1));
    waitFlush();

    $display("[TB] reset during fill");
    cmdBefore = cmdCount;
    pushCmd(1'b1, 8'h2D, '0);
    applyStimulus(1'b1, 8'h2D, '0, 1'b0, 1, 1'b1, initVal(8'h2D));
    for (int i = 0; i < 20; i++) begin
      if (cmdCount > cmdBefore) break;
      @(posedge clk);
    end
    checkOutput("fillIssued", 64'(cmdCount), 64'(cmdBefore + 1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    respQ.delete();
    respTarget = respCount;
    #1;
    checkOutputsZero("midReset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("lateReplyIgnored", 64'(respCount), 64'(respTarget));
    checkOutput("lateReplyBusy", 64'(busy), 64'(0));
    pushCmd(1'b1, 8'h2D, '0);
    applyStimulus(1'b1, 8'h2D, '0, 1'b0, 1, 1'b1, initVal(8'h2D));
    waitResp();
    checkQueuesEmpty("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
